// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_pkg: shared types and helpers for the pipeline hazard,
// forwarding and freeze controller.
package pipe_hazard_pkg;

    // Register indices are held in the tracker at this width. The ID-side
    // width (RIDX_W) is zero-extended into it, so RIDX_W must not exceed it.
    localparam int STAGE_RIDX_W = 8;

    // Forwarding select value meaning "take the operand from the register file"
    localparam int FWD_RF = 0;

    typedef enum logic [1:0] {
        LONG_IDLE = 2'd0,
        LONG_BUSY = 2'd1,
        LONG_DONE = 2'd2
    } long_state_e;

    // One tracked downstream stage
    typedef struct packed {
        logic                    valid;
        logic                    reg_wr;
        logic                    is_load;
        logic                    is_long;
        logic [STAGE_RIDX_W-1:0] rd;
    } stage_entry_t;

    // Source operands of the instruction currently in EX (stage 0 only)
    typedef struct packed {
        logic [STAGE_RIDX_W-1:0] rs;
        logic [STAGE_RIDX_W-1:0] rs2;
        logic                    uses_rs;
        logic                    uses_rs2;
    } stage_src_t;

    // A stage supplies src when it holds a live write to that (non-zero) register
    function automatic logic stage_match(input stage_entry_t e,
                                         input logic [STAGE_RIDX_W-1:0] src);
        return e.valid & e.reg_wr & (e.rd != {STAGE_RIDX_W{1'b0}}) & (e.rd == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage instruction fields in, pipeline enables and
// EX operand selects out.
interface pipe_hazard_ctrl_if #(
    parameter int NFWD   = 3,
    parameter int RIDX_W = 5
);
    localparam int FWD_W = $clog2(NFWD);

    logic              id_valid;
    logic [RIDX_W-1:0] id_rs;
    logic [RIDX_W-1:0] id_rs2;
    logic              id_uses_rs;
    logic              id_uses_rs2;
    logic [RIDX_W-1:0] id_rd;
    logic              id_reg_wr;
    logic              id_is_load;
    logic              id_is_long;
    logic              id_branch;
    logic              branch_taken;

    logic              if_id_en;
    logic              pipe_en;
    logic              id_bubble;
    logic              if_flush;
    logic [FWD_W-1:0]  ex_fwd_a;
    logic [FWD_W-1:0]  ex_fwd_b;
    logic              ex_long_start;
    logic              ex_long_done;

    // Datapath / decode side
    modport master (
        output id_valid, id_rs, id_rs2, id_uses_rs, id_uses_rs2, id_rd,
               id_reg_wr, id_is_load, id_is_long, id_branch, branch_taken,
        input  if_id_en, pipe_en, id_bubble, if_flush, ex_fwd_a, ex_fwd_b,
               ex_long_start, ex_long_done
    );

    // Hazard controller side
    modport slave (
        input  id_valid, id_rs, id_rs2, id_uses_rs, id_uses_rs2, id_rd,
               id_reg_wr, id_is_load, id_is_long, id_branch, branch_taken,
        output if_id_en, pipe_en, id_bubble, if_flush, ex_fwd_a, ex_fwd_b,
               ex_long_start, ex_long_done
    );
endinterface

// File: rtl/pipe_hazard_ctrl_long_timer.sv
// pipe_long_timer: freezes the pipeline for LONG_CYC cycles while a
// multi-cycle EX operation runs, then releases it for one DONE cycle.
module pipe_long_timer
    import pipe_hazard_pkg::*;
#(
    parameter int LONG_CYC = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start_cond,
    output logic freeze,
    output logic long_start,
    output logic long_done
);

    localparam int CNT_W = $clog2(LONG_CYC);

    localparam logic [1:0] ST_IDLE = LONG_IDLE;
    localparam logic [1:0] ST_BUSY = LONG_BUSY;
    localparam logic [1:0] ST_DONE = LONG_DONE;

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             freeze_s;
    logic             start_s;
    logic             done_s;

    // Next state, counter update and freeze/pulse decode
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        freeze_s   = 1'b0;
        start_s    = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_cond) begin
                    start_s    = 1'b1;
                    freeze_s   = 1'b1;
                    cnt_nx_s   = CNT_W'(LONG_CYC - 1);
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                freeze_s = 1'b1;
                cnt_nx_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                // The long op leaves EX this cycle; a following one starts from IDLE
                done_s     = 1'b1;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    assign freeze     = freeze_s;
    assign long_start = start_s;
    assign long_done  = done_s;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: tracks NFWD stages behind ID, selects EX forwarding
// sources, detects load-use and branch-operand hazards, and freezes the
// pipeline around long EX operations.
// Optional feature macro: PIPE_BRANCH_FLUSH_EN (squash the instruction
// fetched behind a taken branch; otherwise delay-slot semantics).
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int NFWD     = 3,
    parameter int RIDX_W   = 5,
    parameter int LONG_CYC = 32
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int FWD_W = $clog2(NFWD);

    stage_entry_t            stage_r [NFWD];
    stage_src_t              src_r;
    stage_entry_t            id_entry_s;
    stage_src_t              id_src_s;
    logic [STAGE_RIDX_W-1:0] id_rs_x_s;
    logic [STAGE_RIDX_W-1:0] id_rs2_x_s;
    logic [STAGE_RIDX_W-1:0] id_rd_x_s;

    logic             load_use_s;
    logic             branch_hz_s;
    logic             hazard_s;
    logic             freeze_s;
    logic             long_start_s;
    logic             long_done_s;
    logic             flush_req_s;
    logic [FWD_W-1:0] fwd_a_s;
    logic [FWD_W-1:0] fwd_b_s;
    logic             if_id_en_s;
    logic             pipe_en_s;
    logic             id_bubble_s;
    logic             if_flush_s;

    // Widen ID indices and build the entry stage 0 would load
    always_comb begin
        id_rs_x_s  = {STAGE_RIDX_W{1'b0}};
        id_rs2_x_s = {STAGE_RIDX_W{1'b0}};
        id_rd_x_s  = {STAGE_RIDX_W{1'b0}};
        id_rs_x_s[RIDX_W-1:0]  = bus.id_rs;
        id_rs2_x_s[RIDX_W-1:0] = bus.id_rs2;
        id_rd_x_s[RIDX_W-1:0]  = bus.id_rd;

        id_entry_s         = '0;
        id_entry_s.valid   = 1'b1;
        id_entry_s.reg_wr  = bus.id_reg_wr;
        id_entry_s.is_load = bus.id_is_load;
        id_entry_s.is_long = bus.id_is_long;
        id_entry_s.rd      = id_rd_x_s;

        id_src_s          = '0;
        id_src_s.rs       = id_rs_x_s;
        id_src_s.rs2      = id_rs2_x_s;
        id_src_s.uses_rs  = bus.id_uses_rs;
        id_src_s.uses_rs2 = bus.id_uses_rs2;
    end

    // Load-use and branch-operand hazards seen by the instruction in ID
    always_comb begin
        load_use_s  = stage_r[0].is_load &
                      ((bus.id_uses_rs  & stage_match(stage_r[0], id_rs_x_s)) |
                       (bus.id_uses_rs2 & stage_match(stage_r[0], id_rs2_x_s)));
        branch_hz_s = 1'b0;
        // The last tracked stage is already on the writeback/bypass path for ID
        for (int k = 0; k < NFWD - 1; k++) begin
            branch_hz_s = branch_hz_s | (bus.id_branch & stage_match(stage_r[k], id_rs_x_s));
        end
        hazard_s = bus.id_valid & (load_use_s | branch_hz_s);
    end

    // EX operand sources: the youngest producer (lowest stage number) wins
    always_comb begin
        fwd_a_s = FWD_W'(FWD_RF);
        fwd_b_s = FWD_W'(FWD_RF);
        for (int k = NFWD - 1; k >= 1; k--) begin
            fwd_a_s = (src_r.uses_rs  & stage_match(stage_r[k], src_r.rs))  ? FWD_W'(k) : fwd_a_s;
            fwd_b_s = (src_r.uses_rs2 & stage_match(stage_r[k], src_r.rs2)) ? FWD_W'(k) : fwd_b_s;
        end
    end

    pipe_long_timer #(
        .LONG_CYC (LONG_CYC)
    ) u_long_timer (
        .clk        (clk),
        .reset      (reset),
        .start_cond (stage_r[0].valid & stage_r[0].is_long),
        .freeze     (freeze_s),
        .long_start (long_start_s),
        .long_done  (long_done_s)
    );

`ifdef PIPE_BRANCH_FLUSH_EN
    assign flush_req_s = bus.branch_taken & bus.id_valid;
`else
    // Delay-slot semantics: the fetched instruction always executes
    logic unused_branch_s;
    assign unused_branch_s = bus.branch_taken;
    assign flush_req_s     = 1'b0;
`endif

    // Pipeline enables: freeze beats hazard beats normal flow
    always_comb begin
        if_id_en_s  = 1'b1;
        pipe_en_s   = 1'b1;
        id_bubble_s = 1'b0;
        if_flush_s  = 1'b0;
        if (freeze_s) begin
            if_id_en_s  = 1'b0;
            pipe_en_s   = 1'b0;
            id_bubble_s = 1'b0;
            if_flush_s  = 1'b0;
        end else if (hazard_s) begin
            if_id_en_s  = 1'b0;
            pipe_en_s   = 1'b1;
            id_bubble_s = 1'b1;
            if_flush_s  = 1'b0;
        end else begin
            if_id_en_s  = 1'b1;
            pipe_en_s   = 1'b1;
            id_bubble_s = 1'b0;
            if_flush_s  = flush_req_s;
        end
    end

    // Shift the stage tracker in step with the pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NFWD; k++) begin
                stage_r[k] <= '0;
            end
            src_r <= '0;
        end else if (pipe_en_s) begin
            for (int k = 1; k < NFWD; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
            if (id_bubble_s | ~bus.id_valid) begin
                stage_r[0] <= '0;
                src_r      <= '0;
            end else begin
                stage_r[0] <= id_entry_s;
                src_r      <= id_src_s;
            end
        end
    end

    assign bus.if_id_en      = if_id_en_s;
    assign bus.pipe_en       = pipe_en_s;
    assign bus.id_bubble     = id_bubble_s;
    assign bus.if_flush      = if_flush_s;
    assign bus.ex_fwd_a      = fwd_a_s;
    assign bus.ex_fwd_b      = fwd_b_s;
    assign bus.ex_long_start = long_start_s;
    assign bus.ex_long_done  = long_done_s;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus a randomized run checked
// against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

    localparam int NFWD     = 3;
    localparam int RIDX_W   = 5;
    localparam int LONG_CYC = 4;

`ifdef PIPE_BRANCH_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    typedef struct packed {
        bit       valid;
        bit       reg_wr;
        bit       is_load;
        bit       is_long;
        bit [4:0] rd;
        bit [4:0] rs;
        bit [4:0] rs2;
        bit       uses_rs;
        bit       uses_rs2;
    } instr_t;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    pipe_hazard_ctrl_if #(.NFWD(NFWD), .RIDX_W(RIDX_W)) bus ();

    pipe_hazard_ctrl #(
        .NFWD     (NFWD),
        .RIDX_W   (RIDX_W),
        .LONG_CYC (LONG_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic instr_t mk(bit v, bit [4:0] rd, bit wr, bit [4:0] rs, bit urs,
                                  bit [4:0] rs2, bit urs2, bit ld, bit lg);
        instr_t r;
        r.valid = v; r.rd = rd; r.reg_wr = wr; r.rs = rs; r.uses_rs = urs;
        r.rs2 = rs2; r.uses_rs2 = urs2; r.is_load = ld; r.is_long = lg;
        return r;
    endfunction

    function automatic logic [3:0] ctrl_now();
        return {bus.if_id_en, bus.pipe_en, bus.id_bubble, bus.if_flush};
    endfunction

    task automatic drive_id(input instr_t i, input bit br, input bit tk);
        bus.id_valid     = i.valid;
        bus.id_rs        = i.rs;
        bus.id_rs2       = i.rs2;
        bus.id_uses_rs   = i.uses_rs;
        bus.id_uses_rs2  = i.uses_rs2;
        bus.id_rd        = i.rd;
        bus.id_reg_wr    = i.reg_wr;
        bus.id_is_load   = i.is_load;
        bus.id_is_long   = i.is_long;
        bus.id_branch    = br;
        bus.branch_taken = tk;
    endtask

    // Leaves the bench just after a falling edge with reset released
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_id('0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        tests_run++;
        if (ctrl_now() !== 4'b1100) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected %b", ctrl_now(), 4'b1100);
        end
        tests_run++;
        if ({bus.ex_fwd_a, bus.ex_fwd_b} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_fwd: got %0d/%0d expected 0/0", bus.ex_fwd_a, bus.ex_fwd_b);
        end
        tests_run++;
        if ({bus.ex_long_start, bus.ex_long_done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_long: got %b expected 00", {bus.ex_long_start, bus.ex_long_done});
        end
    endtask

    task automatic test_forwarding();
        // add r3,r1,r2 ; sub r4,r1,r3 back to back -> rs2 from stage 1
        do_reset();
        drive_id(mk(1, 5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id(mk(1, 5'd4, 1, 5'd1, 1, 5'd3, 1, 0, 0), 1'b0, 1'b0);
        #2;
        tests_run++;
        if (bus.ex_fwd_a !== 2'd0) begin
            tests_failed++;
            $display("FAIL fwd_first_add: got %0d expected 0", bus.ex_fwd_a);
        end
        @(negedge clk);
        drive_id('0, 1'b0, 1'b0);
        #2;
        tests_run++;
        if ({bus.ex_fwd_a, bus.ex_fwd_b} !== {2'd0, 2'd1}) begin
            tests_failed++;
            $display("FAIL fwd_back_to_back: got %0d/%0d expected 0/1", bus.ex_fwd_a, bus.ex_fwd_b);
        end
        // add r3 ; or r6,r7,r8 ; sub r4,r3,r1 -> rs from stage 2
        do_reset();
        drive_id(mk(1, 5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id(mk(1, 5'd6, 1, 5'd7, 1, 5'd8, 1, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id(mk(1, 5'd4, 1, 5'd3, 1, 5'd1, 1, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id('0, 1'b0, 1'b0);
        #2;
        tests_run++;
        if ({bus.ex_fwd_a, bus.ex_fwd_b} !== {2'd2, 2'd0}) begin
            tests_failed++;
            $display("FAIL fwd_one_between: got %0d/%0d expected 2/0", bus.ex_fwd_a, bus.ex_fwd_b);
        end
    endtask

    task automatic test_double_match();
        // r3 written at stages 1 and 2: youngest wins
        do_reset();
        drive_id(mk(1, 5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id(mk(1, 5'd3, 1, 5'd5, 1, 5'd0, 0, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id(mk(1, 5'd4, 1, 5'd3, 1, 5'd3, 1, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id('0, 1'b0, 1'b0);
        #2;
        tests_run++;
        if ({bus.ex_fwd_a, bus.ex_fwd_b} !== {2'd1, 2'd1}) begin
            tests_failed++;
            $display("FAIL fwd_double_match: got %0d/%0d expected 1/1", bus.ex_fwd_a, bus.ex_fwd_b);
        end
        // writer of r0 is never a forwarding source
        do_reset();
        drive_id(mk(1, 5'd0, 1, 5'd1, 1, 5'd2, 1, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id(mk(1, 5'd4, 1, 5'd0, 1, 5'd0, 1, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id('0, 1'b0, 1'b0);
        #2;
        tests_run++;
        if ({bus.ex_fwd_a, bus.ex_fwd_b} !== {2'd0, 2'd0}) begin
            tests_failed++;
            $display("FAIL fwd_rd_zero: got %0d/%0d expected 0/0", bus.ex_fwd_a, bus.ex_fwd_b);
        end
        // matching index but operand not read
        do_reset();
        drive_id(mk(1, 5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id(mk(1, 5'd4, 1, 5'd3, 0, 5'd3, 0, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id('0, 1'b0, 1'b0);
        #2;
        tests_run++;
        if ({bus.ex_fwd_a, bus.ex_fwd_b} !== {2'd0, 2'd0}) begin
            tests_failed++;
            $display("FAIL fwd_unused_src: got %0d/%0d expected 0/0", bus.ex_fwd_a, bus.ex_fwd_b);
        end
    endtask

    task automatic test_load_use();
        // lw r5 ; add r6,r5,r2 -> one bubble, then r5 comes from stage 2
        do_reset();
        drive_id(mk(1, 5'd5, 1, 5'd1, 1, 5'd0, 0, 1, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id(mk(1, 5'd6, 1, 5'd5, 1, 5'd2, 1, 0, 0), 1'b0, 1'b0);
        #2;
        tests_run++;
        if (ctrl_now() !== 4'b0110) begin
            tests_failed++;
            $display("FAIL load_use_stall: got %b expected %b", ctrl_now(), 4'b0110);
        end
        @(negedge clk);
        #2;
        tests_run++;
        if (ctrl_now() !== 4'b1100) begin
            tests_failed++;
            $display("FAIL load_use_release: got %b expected %b", ctrl_now(), 4'b1100);
        end
        @(negedge clk);
        drive_id('0, 1'b0, 1'b0);
        #2;
        tests_run++;
        if (bus.ex_fwd_a !== 2'd2) begin
            tests_failed++;
            $display("FAIL load_use_fwd: got %0d expected 2", bus.ex_fwd_a);
        end
    endtask

    task automatic test_branch_hazard();
        logic [3:0] exp_c;
        // addi r7 ; beqz r7 (taken) -> two stall cycles, then accepted
        do_reset();
        drive_id(mk(1, 5'd7, 1, 5'd1, 1, 5'd0, 0, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        drive_id(mk(1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0, 0), 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #2;
            exp_c = (c < 2) ? 4'b0110 : {3'b110, FLUSH_EN};
            tests_run++;
            if (ctrl_now() !== exp_c) begin
                tests_failed++;
                $display("FAIL branch_hazard_c%0d: got %b expected %b", c, ctrl_now(), exp_c);
            end
        end
    endtask

    task automatic test_long_op();
        logic [1:0] exp_l;
        logic [3:0] exp_c;
        // mult in EX for LONG_CYC frozen cycles, a second mult waits in ID
        do_reset();
        drive_id(mk(1, 5'd8, 1, 5'd1, 1, 5'd2, 1, 0, 1), 1'b0, 1'b0);
        @(negedge clk);
        drive_id(mk(1, 5'd9, 1, 5'd10, 1, 5'd11, 1, 0, 1), 1'b0, 1'b0);
        for (int t = 0; t <= LONG_CYC; t++) begin
            if (t > 0) @(negedge clk);
            #2;
            exp_l = (t == 0) ? 2'b10 : ((t == LONG_CYC) ? 2'b01 : 2'b00);
            exp_c = (t == LONG_CYC) ? 4'b1100 : 4'b0000;
            tests_run++;
            if ({bus.ex_long_start, bus.ex_long_done} !== exp_l) begin
                tests_failed++;
                $display("FAIL long_pulse_t%0d: got %b expected %b", t,
                         {bus.ex_long_start, bus.ex_long_done}, exp_l);
            end
            tests_run++;
            if (ctrl_now() !== exp_c) begin
                tests_failed++;
                $display("FAIL long_ctrl_t%0d: got %b expected %b", t, ctrl_now(), exp_c);
            end
        end
        @(negedge clk);
        drive_id('0, 1'b0, 1'b0);
        #2;
        tests_run++;
        if ({bus.ex_long_start, bus.ex_long_done, ctrl_now()} !== 6'b10_0000) begin
            tests_failed++;
            $display("FAIL long_restart: got %b expected %b",
                     {bus.ex_long_start, bus.ex_long_done, ctrl_now()}, 6'b10_0000);
        end
    endtask

    task automatic test_long_reset();
        do_reset();
        drive_id(mk(1, 5'd8, 1, 5'd1, 1, 5'd2, 1, 0, 1), 1'b0, 1'b0);
        @(negedge clk);
        drive_id('0, 1'b0, 1'b0);
        #2;
        tests_run++;
        if (bus.ex_long_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL long_reset_start: got %b expected 1", bus.ex_long_start);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < LONG_CYC + 2; t++) begin
            if (t > 0) @(negedge clk);
            #2;
            tests_run++;
            if ({bus.ex_long_start, bus.ex_long_done, ctrl_now()} !== 6'b00_1100) begin
                tests_failed++;
                $display("FAIL long_reset_idle_t%0d: got %b expected %b", t,
                         {bus.ex_long_start, bus.ex_long_done, ctrl_now()}, 6'b00_1100);
            end
        end
    endtask

    task automatic test_flush();
        // taken jump with no hazard
        do_reset();
        drive_id(mk(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0), 1'b0, 1'b1);
        #2;
        tests_run++;
        if (ctrl_now() !== {3'b110, FLUSH_EN}) begin
            tests_failed++;
            $display("FAIL flush_taken: got %b expected %b", ctrl_now(), {3'b110, FLUSH_EN});
        end
        // taken flag with no valid instruction in ID
        @(negedge clk);
        drive_id('0, 1'b0, 1'b1);
        #2;
        tests_run++;
        if (ctrl_now() !== 4'b1100) begin
            tests_failed++;
            $display("FAIL flush_invalid_id: got %b expected %b", ctrl_now(), 4'b1100);
        end
    endtask

    function automatic instr_t rand_instr();
        instr_t r;
        r          = '0;
        r.valid    = ($urandom_range(0, 7) != 0);
        r.rd       = 5'($urandom_range(0, 3));
        r.reg_wr   = ($urandom_range(0, 3) != 0);
        r.rs       = 5'($urandom_range(0, 3));
        r.rs2      = 5'($urandom_range(0, 3));
        r.uses_rs  = ($urandom_range(0, 3) != 0);
        r.uses_rs2 = ($urandom_range(0, 1) != 0);
        r.is_load  = ($urandom_range(0, 3) == 0);
        r.is_long  = ($urandom_range(0, 19) == 0);
        return r;
    endfunction

    // Model writer check: live write to a non-zero register equal to src
    function automatic bit writes(instr_t r, bit [4:0] src);
        return r.valid && r.reg_wr && (r.rd != 5'd0) && (r.rd == src);
    endfunction

    task automatic test_random();
        instr_t     m [NFWD];      // instruction in each tracked stage
        int         long_left;     // frozen cycles still owed after this one
        bit         done_now;      // this cycle is the long op's release cycle
        instr_t     cur;
        bit         cur_br;
        bit         cur_tk;
        bit         hold;
        bit         rst_now;
        bit         lu;
        bit         bh;
        bit         hz;
        bit         st;
        bit         fz;
        logic [3:0] exp_c;
        logic [1:0] exp_fa;
        logic [1:0] exp_fb;

        do_reset();
        for (int k = 0; k < NFWD; k++) m[k] = '0;
        long_left = 0;
        done_now  = 1'b0;
        hold      = 1'b0;
        cur       = '0;
        cur_br    = 1'b0;
        cur_tk    = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst_now = ($urandom_range(0, 63) == 0);
            if (!hold) begin
                cur    = rand_instr();
                cur_br = ($urandom_range(0, 3) == 0);
                cur_tk = ($urandom_range(0, 1) == 0);
            end
            reset = rst_now;
            drive_id(cur, cur_br, cur_tk);
            #2;

            lu = m[0].is_load && ((cur.uses_rs  && writes(m[0], cur.rs)) ||
                                  (cur.uses_rs2 && writes(m[0], cur.rs2)));
            bh = 1'b0;
            for (int k = 0; k <= NFWD - 2; k++) begin
                if (cur_br && writes(m[k], cur.rs)) bh = 1'b1;
            end
            hz = cur.valid && (lu || bh);
            st = (long_left == 0) && !done_now && m[0].valid && m[0].is_long;
            fz = st || (long_left > 0);
            if (fz)      exp_c = 4'b0000;
            else if (hz) exp_c = 4'b0110;
            else         exp_c = {3'b110, FLUSH_EN && cur_tk && cur.valid};
            exp_fa = 2'd0;
            exp_fb = 2'd0;
            for (int k = 1; k < NFWD; k++) begin
                if (exp_fa == 2'd0 && m[0].uses_rs  && writes(m[k], m[0].rs))  exp_fa = 2'(k);
                if (exp_fb == 2'd0 && m[0].uses_rs2 && writes(m[k], m[0].rs2)) exp_fb = 2'(k);
            end

            tests_run++;
            if (ctrl_now() !== exp_c) begin
                tests_failed++;
                $display("FAIL rand_ctrl cyc %0d: got %b expected %b", cyc, ctrl_now(), exp_c);
            end
            tests_run++;
            if ({bus.ex_fwd_a, bus.ex_fwd_b} !== {exp_fa, exp_fb}) begin
                tests_failed++;
                $display("FAIL rand_fwd cyc %0d: got %0d/%0d expected %0d/%0d", cyc,
                         bus.ex_fwd_a, bus.ex_fwd_b, exp_fa, exp_fb);
            end
            tests_run++;
            if ({bus.ex_long_start, bus.ex_long_done} !== {st, done_now}) begin
                tests_failed++;
                $display("FAIL rand_long cyc %0d: got %b expected %b", cyc,
                         {bus.ex_long_start, bus.ex_long_done}, {st, done_now});
            end

            @(posedge clk);
            if (rst_now) begin
                for (int k = 0; k < NFWD; k++) m[k] = '0;
                long_left = 0;
                done_now  = 1'b0;
            end else begin
                if (!fz) begin
                    for (int k = NFWD - 1; k >= 1; k--) m[k] = m[k-1];
                    m[0] = (hz || !cur.valid) ? instr_t'(0) : cur;
                end
                if (st) begin
                    long_left = LONG_CYC - 1;
                end else if (long_left > 0) begin
                    long_left = long_left - 1;
                    done_now  = (long_left == 0);
                end else begin
                    done_now = 1'b0;
                end
            end
            hold = !rst_now && (exp_c[3] == 1'b0);
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        drive_id('0, 1'b0, 1'b0);
        test_reset();
        test_forwarding();
        test_double_match();
        test_load_use();
        test_branch_hazard();
        test_long_op();
        test_long_reset();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and freeze controller for the pipelined CPU datapath. It generalises the fixed two-source forwarding, load-use detection, branch stall and multiplier freeze into one block with a configurable number of tracked downstream stages. It also adds a configurable multi-cycle EX occupancy timer and an optional branch flush. It sits beside the ID stage and drives every pipeline-register enable plus the EX operand-select muxes.

## Interface
- NFWD, 3, tracked stages after ID (stage 0 = ID/EX … NFWD-1 = last writeback register); ≥2
- RIDX_W, 5, register index width
- LONG_CYC, 32, total freeze cycles for a long EX op (multiply); ≥2
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_valid  in  1  IF/ID holds a valid instruction
- id_rs, id_rs2  in  RIDX_W  ID source indices
- id_uses_rs, id_uses_rs2  in  1  source actually read
- id_rd  in  RIDX_W  final destination (link already resolved to 31)
- id_reg_wr, id_is_load, id_is_long  in  1  ID instruction class
- id_branch  in  1  ID reads rs for branch/jr resolution
- branch_taken  in  1  branch/jump taken this cycle (from ID)
- if_id_en  out  1  PC and IF/ID write enable
- pipe_en  out  1  ID/EX, EX/MEM, MEM/WB write enable
- id_bubble  out  1  load zero control into ID/EX
- if_flush  out  1  load invalid instruction into IF/ID
- ex_fwd_a, ex_fwd_b  out  $clog2(NFWD)  0 = register file, k = value from stage k
- ex_long_start, ex_long_done  out  1  single-cycle pulses to the EX multi-cycle unit

## Operation
- Stage tracker, NFWD entries. Each entry holds {valid, reg_wr, is_load, rd}. Stage 0 also holds {rs, rs2, uses_rs, uses_rs2}.
- When pipe_en=1:
  - Stage 0 loads the ID fields. It loads all zero if id_bubble=1 or id_valid=0.
  - Stage k loads stage k-1.
- Match at stage k: valid & reg_wr & rd≠0 & rd==src.
- Forwarding is for the EX instruction. It uses stage 0 rs/rs2 and their uses flags.
  - The lowest k in 1..NFWD-1 that matches wins.
  - With no match, the select is 0.
- Load-use hazard: stage 0 is valid & is_load, and its rd matches a used ID source.
- Branch hazard: id_branch=1, and any stage 0..NFWD-2 matches id_rs.
- hazard = id_valid & (load-use | branch hazard).
- Long-op FSM, three states:
  - IDLE → BUSY when stage 0 is valid & is_long. On that cycle: ex_long_start=1, freeze=1, cnt←LONG_CYC-1.
  - BUSY: freeze=1, cnt decrements. Moves to DONE on the cycle cnt==1.
  - DONE: freeze=0, ex_long_done=1, return to IDLE. The op advances this cycle.
  - A long op following directly restarts from IDLE on the next cycle.
- Output priority:
  - freeze: if_id_en=0, pipe_en=0, id_bubble=0, if_flush=0.
  - else hazard: if_id_en=0, pipe_en=1, id_bubble=1, if_flush=0.
  - else: if_id_en=1, pipe_en=1, id_bubble=0, if_flush per Configuration.
- branch_taken is ignored while hazard or freeze is active.

## Timing
- Hazard and forwarding outputs are combinational from the stage registers and the ID inputs. There are no added cycles.
- Reset (synchronous): all stage entries zero, FSM IDLE, cnt 0.
  - After reset: if_id_en=1, pipe_en=1, others 0.
- A long op freezes exactly LONG_CYC cycles, including the start cycle, then advances on the DONE cycle.
- Reset during BUSY returns to IDLE on the next edge. No ex_long_done is issued.
- A load-use stall costs one bubble. A branch hazard holds until the producer leaves stage NFWD-2.

## Configuration
- PIPE_BRANCH_FLUSH_EN defined:
  - if_flush = branch_taken & ~hazard & ~freeze & id_valid.
  - The instruction fetched behind a taken branch is squashed (no delay slot).
- Undefined: if_flush is tied 0, giving delay-slot semantics.

## Structure
- Package pipe_hazard_pkg:
  - stage-entry struct
  - FSM state enum {LONG_IDLE, LONG_BUSY, LONG_DONE}
  - forwarding-select constant FWD_RF=0
- Sub-module pipe_long_timer: FSM plus down-counter, parameter LONG_CYC. Inputs: start condition, reset. Outputs: freeze, start and done pulses.

## Test plan
- Back-to-back dependency: add r3 then sub r4,r3,r1 → ex_fwd_a=1 with sub in EX; one instruction between → ex_fwd_a=2.
- Double match: r3 written at stages 1 and 2 → ex_fwd_a=1; rd=0 writer → select 0.
- Load-use: lw r5 in stage 0, ID uses r5 → exactly one cycle with if_id_en=0, id_bubble=1; then ex_fwd=2.
- Branch hazard: beqz r7 in ID, r7 producer in stage 0 → stall 2 cycles (NFWD=3), then branch_taken accepted.
- Long op, LONG_CYC=4: start pulse at t0; pipe_en=0 t0–t3; ex_long_done and pipe_en=1 at t4; reset at t2 → IDLE at t3, no done pulse.
- Flush: with PIPE_BRANCH_FLUSH_EN, a taken branch with no hazard → if_flush=1 for one cycle; without the macro if_flush stays 0.
